mem_arbiter: RTL and testbench

Memory-side arbiter between the instruction cache and the data cache of one core and the single-ported RAM. It consumes the dcache's `dREN`/`dWEN`/`daddr`/`dstore` word requests, including write-back and fetch bursts, and the icache's `iREN`/`iaddr` requests. It grants one requester at a time and drives the RAM handshake. It returns `dwait`/`dload` and `iwait`/`iload`, and flags a stalled RAM through a sticky timeout bit.

---
 rtl/aww_types_pkg.sv | 10 +
 rtl/cpu_types_pkg.sv | 13 +
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aww_types_pkg.sv
// State encodings for the cache-side controllers and the memory arbiter.
package aww_types_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-side types: RAM handshake state and the machine word.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Grants the single-ported RAM to either the dcache or the icache, holding a
// dcache grant across whole bursts, and flags a RAM that stops answering.
module mem_arbiter
  import cpu_types_pkg::*;
  import aww_types_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        ram_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t       state_r, state_s;
  logic             last_d_r, last_d_s;
  logic [CNT_W-1:0] stall_cnt_r, stall_cnt_s;
  logic             ram_timeout_r, ram_timeout_s;
  logic             dreq_s, access_s;

  assign dreq_s      = dREN | dWEN;
  assign access_s    = (ramstate_t'(ramstate) == ACCESS);
  assign dload       = ramload;
  assign iload       = ramload;
  assign ram_timeout = ram_timeout_r;

  // Grant selection and RAM/cache handshake; completion is same-cycle as ACCESS.
  always_comb begin
    state_s  = state_r;
    last_d_s = last_d_r;
    dwait    = 1'b1;
    iwait    = 1'b1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'h0000_0000;
    ramstore = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        // last_d breaks the tie so simultaneous requesters alternate.
        if (dreq_s && (!iREN || !last_d_r)) begin
          state_s = GNT_D;
        end else if (iREN) begin
          state_s = GNT_I;
        end else begin
          state_s = IDLE;
        end
      end
      GNT_D: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = ~access_s;
        if (!dreq_s) begin
          state_s  = IDLE;
          last_d_s = 1'b1;
        end else begin
          state_s = GNT_D;
        end
      end
      GNT_I: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        iwait   = ~access_s;
        if (access_s && dreq_s) begin
          state_s  = IDLE;
          last_d_s = 1'b0;
        end else if (!iREN) begin
          state_s = IDLE;
        end else begin
          state_s = GNT_I;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Saturating count of consecutive non-ACCESS cycles under one grant.
  always_comb begin
    stall_cnt_s = stall_cnt_r;
    if ((state_r == IDLE) || access_s) begin
      stall_cnt_s = '0;
    end else if (stall_cnt_r == CNT_MAX) begin
      stall_cnt_s = stall_cnt_r;
    end else begin
      stall_cnt_s = stall_cnt_r + CNT_ONE;
    end
    ram_timeout_s = ram_timeout_r | (stall_cnt_s == CNT_MAX);
  end

  // State, round-robin bit, stall counter and sticky timeout registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r       <= IDLE;
      last_d_r      <= 1'b0;
      stall_cnt_r   <= '0;
      ram_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      last_d_r      <= last_d_s;
      stall_cnt_r   <= stall_cnt_s;
      ram_timeout_r <= ram_timeout_s;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural owner/round-robin model.
module tb_mem_arbiter;

  localparam int TO = 4;
  localparam logic [1:0] RS_FREE = 2'd0;
  localparam logic [1:0] RS_BUSY = 2'd1;
  localparam logic [1:0] RS_ACC  = 2'd2;
  localparam logic [1:0] RS_ERR  = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        dREN, dWEN, iREN;
  logic [31:0] daddr, dstore, iaddr, ramload;
  logic [1:0]  ramstate;
  logic        dwait, iwait, ramREN, ramWEN, ram_timeout;
  logic [31:0] dload, iload, ramaddr, ramstore;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ram_timeout(ram_timeout)
  );

  // Reference model: who owns the RAM (0 none, 1 dcache, 2 icache), who was
  // served last, and how long the current owner has been kept waiting.
  int m_owner = 0;
  bit m_last_d = 1'b0;
  int m_stall = 0;
  bit m_to = 1'b0;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_owner <= 0; m_last_d <= 1'b0; m_stall <= 0; m_to <= 1'b0;
    end else begin
      case (m_owner)
        0: if ((dREN || dWEN) && (!iREN || !m_last_d)) m_owner <= 1;
           else if (iREN) m_owner <= 2;
        1: if (!(dREN || dWEN)) begin m_owner <= 0; m_last_d <= 1'b1; end
        default: if (ramstate == RS_ACC && (dREN || dWEN)) begin
                   m_owner <= 0; m_last_d <= 1'b0;
                 end else if (!iREN) m_owner <= 0;
      endcase
      if (m_owner == 0 || ramstate == RS_ACC) m_stall <= 0;
      else begin
        if (m_stall < TO) m_stall <= m_stall + 1;
        if (m_stall + 1 >= TO) m_to <= 1'b1;
      end
    end
  end

  logic [4:0]  exp_ctl;   // {dwait, iwait, ramREN, ramWEN, ram_timeout}
  logic [31:0] exp_addr, exp_store;
  always_comb begin
    exp_ctl[4] = !(m_owner == 1 && ramstate == RS_ACC);
    exp_ctl[3] = !(m_owner == 2 && ramstate == RS_ACC);
    exp_ctl[2] = (m_owner == 1) ? (dREN && !dWEN) : (m_owner == 2);
    exp_ctl[1] = (m_owner == 1) && dWEN;
    exp_ctl[0] = m_to;
    exp_addr   = (m_owner == 1) ? daddr : (m_owner == 2) ? iaddr : 32'h0;
    exp_store  = (m_owner == 1) ? dstore : 32'h0;
  end

  task automatic settle_idle();
    dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0; ramstate = RS_FREE;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset();
    nRST = 1'b0; dREN = 1'b1; dWEN = 1'b0; iREN = 1'b1;
    daddr = 32'h40; iaddr = 32'h80; dstore = $urandom; ramload = $urandom; ramstate = RS_ACC;
    #3;
    n_checks++;
    if ({dwait, iwait, ramREN, ramWEN, ram_timeout} !== 5'b11000)
      $display("FAIL reset_ctl got %b want 11000", {dwait, iwait, ramREN, ramWEN, ram_timeout});
    else n_pass++;
    #4;
    n_checks++;
    if (ramaddr !== 32'h0 || ramstore !== 32'h0 || ramREN !== 1'b0)
      $display("FAIL reset_bus got addr %h store %h ren %b want 0", ramaddr, ramstore, ramREN);
    else n_pass++;
    n_checks++;
    if (dload !== ramload || iload !== ramload)
      $display("FAIL reset_load got %h/%h want %h", dload, iload, ramload);
    else n_pass++;
    @(negedge CLK);
    dREN = 1'b0; iREN = 1'b0; ramstate = RS_FREE; nRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_single_read();
    dREN = 1'b1; daddr = 32'h40; ramstate = RS_FREE; #1;
    n_checks++;
    if (ramREN !== 1'b0 || dwait !== 1'b1)
      $display("FAIL sr_turnaround got ren %b dwait %b want 0 1", ramREN, dwait);
    else n_pass++;
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      ramstate = RS_BUSY; #1;
      n_checks++;
      if ({ramREN, ramWEN, dwait, iwait} !== 4'b1011 || ramaddr !== 32'h40)
        $display("FAIL sr_busy got %b addr %h want 1011 addr 40", {ramREN, ramWEN, dwait, iwait}, ramaddr);
      else n_pass++;
      @(negedge CLK);
    end
    ramstate = RS_ACC; ramload = 32'hDEADBEEF; #1;
    n_checks++;
    if (dwait !== 1'b0 || iwait !== 1'b1 || dload !== 32'hDEADBEEF)
      $display("FAIL sr_access got dwait %b iwait %b dload %h want 0 1 deadbeef", dwait, iwait, dload);
    else n_pass++;
    @(negedge CLK);
    dREN = 1'b0; ramstate = RS_FREE; #1;
    n_checks++;
    if (dwait !== 1'b1) $display("FAIL sr_after got dwait %b want 1", dwait);
    else n_pass++;
    @(negedge CLK);
  endtask

  task automatic test_burst_lock();
    logic [31:0] addrs [4];
    addrs = '{32'h80, 32'h84, 32'h100, 32'h104};
    iaddr = 32'h2000; iREN = 1'b0; dWEN = 1'b1; dREN = 1'b0;
    daddr = addrs[0]; dstore = $urandom; ramstate = RS_FREE;
    @(negedge CLK);
    iREN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      daddr = addrs[c]; dWEN = (c < 2); dREN = (c >= 2);
      dstore = $urandom; ramload = $urandom; ramstate = RS_ACC; #1;
      n_checks++;
      if (dwait !== 1'b0 || iwait !== 1'b1 || ramaddr !== addrs[c] || ramWEN !== (c < 2) ||
          ramREN !== (c >= 2) || (c < 2 && ramstore !== dstore) || (c >= 2 && dload !== ramload))
        $display("FAIL burst_word%0d got dwait %b addr %h wen %b ren %b want 0 %h %b %b",
                 c, dwait, ramaddr, ramWEN, ramREN, addrs[c], (c < 2), (c >= 2));
      else n_pass++;
      @(negedge CLK);
    end
    dWEN = 1'b0; dREN = 1'b0; daddr = 32'h0; ramstate = RS_FREE; #1;
    n_checks++;
    if (ramaddr === iaddr || iwait !== 1'b1)
      $display("FAIL burst_release got addr %h iwait %b want not %h and 1", ramaddr, iwait, iaddr);
    else n_pass++;
    @(negedge CLK); #1;
    n_checks++;
    if ({ramREN, ramWEN} !== 2'b00) $display("FAIL burst_idle got %b want 00", {ramREN, ramWEN});
    else n_pass++;
    @(negedge CLK);
    ramstate = RS_ACC; ramload = $urandom; #1;
    n_checks++;
    if (ramaddr !== iaddr || ramREN !== 1'b1 || iwait !== 1'b0 || iload !== ramload)
      $display("FAIL burst_then_i got addr %h ren %b iwait %b want %h 1 0", ramaddr, ramREN, iwait, iaddr);
    else n_pass++;
    @(negedge CLK);
    settle_idle();
  endtask

  task automatic test_round_robin();
    int prev = 0; int cur; int ncomp = 0; bit alt_ok = 1'b1; bit hold = 1'b0;
    daddr = 32'h300; iaddr = 32'h500; iREN = 1'b1; dWEN = 1'b0;
    for (int c = 0; c < 24; c++) begin
      dREN = !hold; ramload = $urandom; ramstate = RS_FREE; #1;
      if (ramREN || ramWEN) ramstate = RS_ACC;
      #1;
      n_checks++;
      if ({dwait, iwait, ramREN, ramWEN, ram_timeout} !== exp_ctl || ramaddr !== exp_addr)
        $display("FAIL rr_cycle%0d got %b %h want %b %h", c,
                 {dwait, iwait, ramREN, ramWEN, ram_timeout}, ramaddr, exp_ctl, exp_addr);
      else n_pass++;
      hold = (dwait == 1'b0);
      if (dwait == 1'b0 || iwait == 1'b0) begin
        cur = (dwait == 1'b0) ? 1 : 2;
        if (cur == prev) alt_ok = 1'b0;
        prev = cur; ncomp++;
      end
      @(negedge CLK);
    end
    n_checks++;
    if (!alt_ok || ncomp < 6)
      $display("FAIL rr_alternation got alternating %b completions %0d want 1 and >=6", alt_ok, ncomp);
    else n_pass++;
    settle_idle();
  endtask

  task automatic test_preemption();
    // per cycle: dREN, iaddr, ramstate, expected {dwait,iwait,ramREN}, expected ramaddr
    logic        t_d   [7];
    logic [31:0] t_ia  [7];
    logic [1:0]  t_rs  [7];
    logic [2:0]  t_ctl [7];
    logic [31:0] t_ad  [7];
    t_d   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    t_ia  = '{32'h700, 32'h700, 32'h700, 32'h704, 32'h704, 32'h708, 32'h708};
    t_rs  = '{RS_FREE, RS_BUSY, RS_ACC, RS_BUSY, RS_ACC, RS_FREE, RS_ACC};
    t_ctl = '{3'b110, 3'b111, 3'b101, 3'b111, 3'b101, 3'b110, 3'b011};
    t_ad  = '{32'h0, 32'h700, 32'h700, 32'h704, 32'h704, 32'h0, 32'h900};
    daddr = 32'h900; dWEN = 1'b0; iREN = 1'b1;
    for (int c = 0; c < 7; c++) begin
      dREN = t_d[c]; iaddr = t_ia[c]; ramstate = t_rs[c]; #1;
      n_checks++;
      if ({dwait, iwait, ramREN} !== t_ctl[c] || ramaddr !== t_ad[c])
        $display("FAIL preempt_cycle%0d got %b %h want %b %h", c, {dwait, iwait, ramREN}, ramaddr, t_ctl[c], t_ad[c]);
      else n_pass++;
      @(negedge CLK);
    end
    settle_idle();
  endtask

  task automatic test_timeout();
    #1;
    n_checks++;
    if (ram_timeout !== 1'b0) $display("FAIL to_initial got %b want 0", ram_timeout);
    else n_pass++;
    dREN = 1'b1; daddr = 32'hA0; iREN = 1'b0; ramstate = RS_ERR;
    @(negedge CLK);
    for (int k = 1; k <= 5; k++) begin
      #1;
      n_checks++;
      if (dwait !== 1'b1 || ramREN !== 1'b1 || ramaddr !== 32'hA0 || ram_timeout !== (k > TO))
        $display("FAIL to_err%0d got dwait %b ren %b addr %h to %b want 1 1 a0 %b",
                 k, dwait, ramREN, ramaddr, ram_timeout, (k > TO));
      else n_pass++;
      @(negedge CLK);
    end
    ramstate = RS_ACC; ramload = $urandom; #1;
    n_checks++;
    if (dwait !== 1'b0 || dload !== ramload || ram_timeout !== 1'b1)
      $display("FAIL to_recover got dwait %b to %b want 0 1", dwait, ram_timeout);
    else n_pass++;
    @(negedge CLK);
    settle_idle(); #1;
    n_checks++;
    if (ram_timeout !== 1'b1) $display("FAIL to_sticky got %b want 1", ram_timeout);
    else n_pass++;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_burst();
    dWEN = 1'b1; daddr = 32'hB0; dstore = $urandom; ramstate = RS_BUSY;
    @(negedge CLK); #1;
    n_checks++;
    if (ramWEN !== 1'b1 || ramaddr !== 32'hB0)
      $display("FAIL rmb_grant got wen %b addr %h want 1 b0", ramWEN, ramaddr);
    else n_pass++;
    ramstate = RS_ACC; #1;
    nRST = 1'b0; #1;
    n_checks++;
    if (ramWEN !== 1'b0 || dwait !== 1'b1 || ramaddr !== 32'h0 || ram_timeout !== 1'b0)
      $display("FAIL rmb_async got wen %b dwait %b addr %h to %b want 0 1 0 0", ramWEN, dwait, ramaddr, ram_timeout);
    else n_pass++;
    @(negedge CLK);
    nRST = 1'b1; ramstate = RS_BUSY; #1;
    n_checks++;
    if (ramWEN !== 1'b0 || dwait !== 1'b1)
      $display("FAIL rmb_idle got wen %b dwait %b want 0 1", ramWEN, dwait);
    else n_pass++;
    @(negedge CLK); #1;
    n_checks++;
    if (ramWEN !== 1'b1 || ramaddr !== 32'hB0)
      $display("FAIL rmb_regrant got wen %b addr %h want 1 b0", ramWEN, ramaddr);
    else n_pass++;
    @(negedge CLK);
    settle_idle();
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 400; c++) begin
      dWEN = ($urandom % 4 == 0); dREN = ($urandom % 2 == 0); iREN = ($urandom % 3 != 0);
      daddr = $urandom; dstore = $urandom; iaddr = $urandom; ramload = $urandom;
      r = $urandom % 8;
      ramstate = (r < 4) ? RS_ACC : (r == 4) ? RS_FREE : (r == 7) ? RS_ERR : RS_BUSY;
      #1;
      n_checks++;
      if ({dwait, iwait, ramREN, ramWEN, ram_timeout} !== exp_ctl)
        $display("FAIL rand_ctl%0d got %b want %b", c, {dwait, iwait, ramREN, ramWEN, ram_timeout}, exp_ctl);
      else n_pass++;
      n_checks++;
      if (ramaddr !== exp_addr || ramstore !== exp_store || dload !== ramload || iload !== ramload)
        $display("FAIL rand_bus%0d got %h %h want %h %h", c, ramaddr, ramstore, exp_addr, exp_store);
      else n_pass++;
      if (c == 200) begin
        #1 nRST = 1'b0; #1;
        n_checks++;
        if ({dwait, iwait, ramREN, ramWEN, ram_timeout} !== 5'b11000 || exp_ctl !== 5'b11000)
          $display("FAIL rand_reset got %b model %b want 11000", {dwait, iwait, ramREN, ramWEN, ram_timeout}, exp_ctl);
        else n_pass++;
        @(negedge CLK);
        nRST = 1'b1;
      end else begin
        @(negedge CLK);
      end
    end
    settle_idle();
  endtask

  initial begin
    dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0; daddr = 32'h0; dstore = 32'h0;
    iaddr = 32'h0; ramload = 32'h0; ramstate = RS_FREE;
    test_reset();
    test_single_read();
    test_burst_lock();
    test_round_robin();
    test_preemption();
    test_timeout();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
